// File: rtl/relu_pool.sv
// relu_pool: 2x2/stride-2 max pooling with ReLU over a fixed 8x8 feature map.
// Walks the 64 input words window by window (row-major over the 4x4 output),
// keeps a signed running max per window and writes the rectified max of each
// window to the 4x4 output buffer. A start word of 1 launches one run; the
// block then parks in DONE (status=1) until control returns to 0.
module relu_pool (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] control,
  input  logic [31:0] rd_data,
  output logic [11:0] rd_addr,
  output logic [11:0] wr_addr,
  output logic [31:0] wr_data,
  output logic [3:0]  we,
  output logic [31:0] status
);

  localparam int DATA_W = 32;
  localparam int ADDR_W = 12;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t state;

  // Read index within the run; k = 4*m + j where m is the output index
  // (m = 4*pr + pc) and j selects the window corner (j[1] = row, j[0] = col).
  // Reused as the two-cycle counter while draining.
  logic [5:0] k_p0;

  // Sample stage: rd_data carries the data of read idx_p1 when vld_p1 is set.
  logic                     vld_p1;
  logic [5:0]               idx_p1;
  logic signed [DATA_W-1:0] max_p1;
  logic signed [DATA_W-1:0] samp_p1;
  logic signed [DATA_W-1:0] next_max_p1;
  logic                     first_p1;
  logic                     last_p1;

  logic go;
  logic stop;

  // Byte address of read k into the 8x8 buffer: row 2*pr + j[1], col 2*pc + j[0].
  function automatic logic [ADDR_W-1:0] read_addr(input logic [5:0] k);
    logic [ADDR_W-1:0] r;
    logic [ADDR_W-1:0] c;
    r = {9'd0, k[5:4], k[1]};
    c = {9'd0, k[3:2], k[0]};
    return (r * 12'd8 + c) * 12'd4;
  endfunction

  // Byte address of output m into the 4x4 buffer.
  function automatic logic [ADDR_W-1:0] write_addr(input logic [3:0] m);
    return {8'd0, m} * 12'd4;
  endfunction

  // Running max: the first sample of a window loads, later samples replace
  // the held value only when strictly greater (signed compare).
  function automatic logic signed [DATA_W-1:0] win_max(
    input logic                     first,
    input logic signed [DATA_W-1:0] cur,
    input logic signed [DATA_W-1:0] samp
  );
    if (first) begin
      return samp;
    end
    return (samp > cur) ? samp : cur;
  endfunction

  // ReLU clamp: anything not strictly positive (including the most negative
  // word) becomes zero.
  function automatic logic [DATA_W-1:0] relu(input logic signed [DATA_W-1:0] v);
    return (v > 0) ? $unsigned(v) : '0;
  endfunction

  assign go          = (control == 32'd1);
  assign stop        = (control == 32'd0);
  assign samp_p1     = $signed(rd_data);
  assign first_p1    = (idx_p1[1:0] == 2'd0);
  assign last_p1     = (idx_p1[1:0] == 2'd3);
  assign next_max_p1 = win_max(first_p1, max_p1, samp_p1);

  // Stage p0: sequencing FSM, read address issue and done flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      k_p0    <= '0;
      rd_addr <= '0;
      status  <= '0;
    end else begin
      case (state)
        IDLE: begin
          k_p0    <= '0;
          rd_addr <= '0;
          status  <= '0;
          if (go) begin
            state <= RUN;
          end
        end
        RUN: begin
          k_p0 <= k_p0 + 6'd1;
          if (k_p0 == 6'd63) begin
            state   <= DRAIN;
            rd_addr <= '0;
          end else begin
            rd_addr <= read_addr(k_p0 + 6'd1);
          end
        end
        DRAIN: begin
          k_p0 <= k_p0 + 6'd1;
          if (k_p0 == 6'd1) begin
            state  <= DONE;
            status <= 32'd1;
          end
        end
        DONE: begin
          status <= 32'd1;
          if (stop) begin
            state  <= IDLE;
            status <= '0;
          end
        end
        default: begin
          state   <= IDLE;
          k_p0    <= '0;
          rd_addr <= '0;
          status  <= '0;
        end
      endcase
    end
  end

  // Stage p1: remember which read the memory is returning this cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      vld_p1 <= 1'b0;
      idx_p1 <= '0;
    end else begin
      vld_p1 <= (state == RUN);
      idx_p1 <= k_p0;
    end
  end

  // Stage p2: fold the sample into the running max and emit the rectified
  // result on the last sample of each window.
  always_ff @(posedge clk) begin
    if (reset) begin
      max_p1  <= '0;
      we      <= '0;
      wr_addr <= '0;
      wr_data <= '0;
    end else begin
      we <= '0;
      if (vld_p1) begin
        max_p1 <= next_max_p1;
        if (last_p1) begin
          we      <= 4'hf;
          wr_addr <= write_addr(idx_p1[5:2]);
          wr_data <= relu(next_max_p1);
        end
      end
    end
  end

endmodule

// File: tb/tb_relu_pool.sv
// tb_relu_pool: randomized and directed runs of relu_pool against a
// behavioural pooling model computed straight from the feature map.
module tb_relu_pool;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] control;
  logic [31:0] rd_data;
  logic [11:0] rd_addr;
  logic [11:0] wr_addr;
  logic [31:0] wr_data;
  logic [3:0]  we;
  logic [31:0] status;

  relu_pool dut (
    .clk     (clk),
    .reset   (reset),
    .control (control),
    .rd_data (rd_data),
    .rd_addr (rd_addr),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .we      (we),
    .status  (status)
  );

  always #5 clk = ~clk;

  // Feature buffer: synchronous read, data one cycle after the address.
  logic [31:0] fmap [64];
  always @(posedge clk) rd_data <= fmap[rd_addr[7:2]];

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  // Expected read order, built from the window walk.
  logic [11:0] exp_addr [64];

  // Pooled and rectified output m, using plain signed integers.
  function automatic logic [31:0] exp_out(input int m);
    int pr, pc, best, v;
    pr = m / 4;
    pc = m % 4;
    best = fmap[(2 * pr) * 8 + 2 * pc];
    for (int dr = 0; dr < 2; dr++)
      for (int dc = 0; dc < 2; dc++) begin
        v = fmap[(2 * pr + dr) * 8 + (2 * pc + dc)];
        if (v > best) best = v;
      end
    return (best > 0) ? 32'(best) : 32'd0;
  endfunction

  // Captured run observations.
  int          wcount;
  int          wcyc [32];
  logic [11:0] waddr [32];
  logic [31:0] wdat [32];
  logic [3:0]  wwe [32];
  logic [11:0] atrace [64];
  int          st_first;
  logic [31:0] st_val;

  // Start a run from IDLE and observe ncyc cycles; cycle 0 is k=0.
  // control drops to 0 in cycle drop_at (never if negative); reset is
  // high during cycle rst_at (never if negative).
  task automatic run_capture(input int drop_at, input int rst_at, input int ncyc);
    wcount   = 0;
    st_first = -1;
    st_val   = 32'd0;
    control  = 32'd1;
    @(posedge clk); #1;
    for (int c = 0; c < ncyc; c++) begin
      if (c < 64) atrace[c] = rd_addr;
      if (we != 4'd0 && wcount < 32) begin
        wcyc[wcount]  = c;
        waddr[wcount] = wr_addr;
        wdat[wcount]  = wr_data;
        wwe[wcount]   = we;
        wcount++;
      end
      if (status != 32'd0 && st_first < 0) begin
        st_first = c;
        st_val   = status;
      end
      if (c == drop_at) control = 32'd0;
      reset = (c == rst_at);
      @(posedge clk); #1;
    end
    reset = 1'b0;
  endtask

  task automatic check_run(input string tag);
    int bad;
    chk_eq($sformatf("%s.writes", tag), 32'(wcount), 32'd16);
    for (int i = 0; i < 16 && i < wcount; i++) begin
      chk_eq($sformatf("%s.wcyc%0d", tag, i), 32'(wcyc[i]), 32'(4 * i + 5));
      chk_eq($sformatf("%s.waddr%0d", tag, i), 32'(waddr[i]), 32'(4 * i));
      chk_eq($sformatf("%s.wdata%0d", tag, i), wdat[i], exp_out(i));
      chk_eq($sformatf("%s.we%0d", tag, i), 32'(wwe[i]), 32'hf);
    end
    bad = 0;
    for (int c = 0; c < 64; c++) if (atrace[c] !== exp_addr[c]) bad++;
    chk_eq($sformatf("%s.rd_addr_trace_bad", tag), 32'(bad), 32'd0);
    chk_eq($sformatf("%s.status_cycle", tag), 32'(st_first), 32'd66);
    chk_eq($sformatf("%s.status_val", tag), st_val, 32'd1);
  endtask

  task automatic fill_random();
    for (int i = 0; i < 64; i++)
      fmap[i] = ($urandom_range(0, 1) == 1) ? $urandom
                                            : 32'($urandom_range(0, 200)) - 32'd100;
  endtask

  initial begin
    int idx, bad;
    idx = 0;
    for (int pr = 0; pr < 4; pr++)
      for (int pc = 0; pc < 4; pc++)
        for (int dr = 0; dr < 2; dr++)
          for (int dc = 0; dc < 2; dc++) begin
            exp_addr[idx] = 12'(4 * (8 * (2 * pr + dr) + (2 * pc + dc)));
            idx++;
          end
    for (int i = 0; i < 64; i++) fmap[i] = 32'd0;

    // Reset state
    reset   = 1'b1;
    control = 32'd0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    chk_eq("rst.rd_addr", 32'(rd_addr), 32'd0);
    chk_eq("rst.wr_addr", 32'(wr_addr), 32'd0);
    chk_eq("rst.wr_data", wr_data, 32'd0);
    chk_eq("rst.we", 32'(we), 32'd0);
    chk_eq("rst.status", status, 32'd0);
    repeat (2) @(posedge clk);
    #1;

    // Ramp map, pulsed start
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 8; c++) fmap[r * 8 + c] = 32'(8 * r + c - 32);
    run_capture(0, -1, 68);
    check_run("ramp");
    chk_eq("ramp.addr0", 32'(atrace[0]), 32'd0);
    chk_eq("ramp.addr1", 32'(atrace[1]), 32'd4);
    chk_eq("ramp.addr2", 32'(atrace[2]), 32'd32);
    chk_eq("ramp.addr3", 32'(atrace[3]), 32'd36);
    chk_eq("ramp.addr4", 32'(atrace[4]), 32'd8);
    chk_eq("ramp.addr5", 32'(atrace[5]), 32'd12);
    chk_eq("ramp.addr6", 32'(atrace[6]), 32'd40);
    chk_eq("ramp.addr7", 32'(atrace[7]), 32'd44);
    chk_eq("ramp.addr63", 32'(atrace[63]), 32'd252);
    chk_eq("ramp.out0", wdat[0], 32'd0);
    chk_eq("ramp.out7", wdat[7], 32'd0);
    chk_eq("ramp.out8", wdat[8], 32'd9);
    chk_eq("ramp.out11", wdat[11], 32'd15);
    chk_eq("ramp.out12", wdat[12], 32'd25);
    chk_eq("ramp.out15", wdat[15], 32'd31);
    chk_eq("ramp.idle_status", status, 32'd0);

    // Signed compare / ReLU corners; control dropped at k=10
    fill_random();
    fmap[0]  = 32'h8000_0000; fmap[1]  = 32'hFFFF_FFFF;
    fmap[8]  = 32'h7FFF_FFFF; fmap[9]  = 32'h0000_0000;
    fmap[2]  = 32'hFFFF_FFFE; fmap[3]  = 32'hFFFF_FFFE;
    fmap[10] = 32'hFFFF_FFFE; fmap[11] = 32'hFFFF_FFFE;
    fmap[4]  = 32'h8000_0000; fmap[5]  = 32'h8000_0000;
    fmap[12] = 32'h8000_0000; fmap[13] = 32'h8000_0000;
    run_capture(10, -1, 68);
    check_run("signed");
    chk_eq("signed.win0", wdat[0], 32'h7FFF_FFFF);
    chk_eq("signed.win1", wdat[1], 32'd0);
    chk_eq("signed.win2", wdat[2], 32'd0);

    // Handshake: control held through DONE, then released, then rerun
    fill_random();
    run_capture(-1, -1, 70);
    check_run("hold");
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      if (status !== 32'd1 || we !== 4'd0 || rd_addr !== 12'd0) bad++;
      @(posedge clk); #1;
    end
    chk_eq("hold.done_stays_bad", 32'(bad), 32'd0);
    control = 32'd0;
    @(posedge clk); #1;
    chk_eq("hold.release_status", status, 32'd0);
    @(posedge clk); #1;
    run_capture(0, -1, 68);
    check_run("rerun");

    // Reset at k=30 drops the run
    fill_random();
    run_capture(0, 30, 32);
    chk_eq("rstrun.writes_before", 32'(wcount), 32'd7);
    bad = 0;
    for (int i = 0; i < 8; i++) begin
      if (we !== 4'd0 || rd_addr !== 12'd0 || status !== 32'd0) bad++;
      @(posedge clk); #1;
    end
    chk_eq("rstrun.idle_bad", 32'(bad), 32'd0);
    fill_random();
    run_capture(0, -1, 68);
    check_run("after_rst");

    // Reset in the first drain cycle kills the pending final write
    fill_random();
    run_capture(0, 64, 68);
    chk_eq("rstdrain.writes", 32'(wcount), 32'd15);
    chk_eq("rstdrain.no_done", 32'(st_first), 32'hFFFF_FFFF);
    fill_random();
    run_capture(0, -1, 68);
    check_run("final");

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/relu_pool.md
RELU_POOL -- requirements
Module: relu_pool

Interface
REQ-001 SHALL have one clock, clk; reset is synchronous and active-high, named reset.
REQ-002 SHALL have ports, one per line, as follows:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous active-high reset
- control  input  32  start/handshake word; only value 1 is "go"
- rd_data  input  32  signed word from feature buffer; valid 1 cycle after rd_addr
- rd_addr  output  12  byte address into 8x8 feature buffer, 4*(8*r+c)
- wr_addr  output  12  byte address into 4x4 output buffer, 4*(4*pr+pc)
- wr_data  output  32  pooled, rectified result
- we  output  4  byte write enables, 4'hf or 0
- status  output  32  1 = done, else 0
REQ-003 SHALL have no parameters; map is fixed at 8x8 in, 4x4 out, 2x2 window, stride 2.

Function
REQ-004 SHALL implement states IDLE(0), RUN(1), DRAIN(2), DONE(3), held in a state register.
REQ-005 IDLE: rd_addr=0, we=0, status=0; go to RUN on the edge where control==1; otherwise stay.
REQ-006 RUN lasts exactly 64 cycles, k=0..63; the cycle after RUN entry is k=0.
REQ-007 Read order in RUN: outputs (pr,pc) row-major, pr,pc in 0..3; per output 4 reads: (2pr,2pc), (2pr,2pc+1), (2pr+1,2pc), (2pr+1,2pc+1).
REQ-008 One read per cycle in RUN.
REQ-009 rd_addr SHALL equal 4*(8*r+c) of read k during cycle k, using full 12-bit arithmetic with no truncation (max 252).
REQ-010 Data of read k SHALL be sampled from rd_data in cycle k+1.
REQ-011 Comparison SHALL be signed 32-bit.
REQ-012 The first sample of each window SHALL load the running max; the next 3 samples SHALL update it when strictly greater.
REQ-013 ReLU: wr_data = running max if > 0, else 0; 0x80000000 maps to 0.
REQ-014 For the window whose last read is k=4m+3, during cycle k+2:
- we=4'hf for exactly that one cycle;
- wr_addr=4*m;
- wr_data=result.
REQ-015 Exactly 16 writes per run, consecutive writes 4 cycles apart.
REQ-016 we SHALL be 0 in all other cycles.
REQ-017 After k=63, go to DRAIN for 2 cycles; the final write (wr_addr=60) occurs in the second DRAIN cycle; then go to DONE.
REQ-018 DONE: status=32'd1 every cycle; go to IDLE on the edge where control==0.
REQ-019 status SHALL be 0 in every state other than DONE.
REQ-020 control is ignored in RUN and DRAIN; deassertion mid-run SHALL NOT abort.
REQ-021 If control stays 1 in DONE, the block SHALL stay in DONE and SHALL NOT restart.
REQ-022 Latency: from RUN entry to status=1 SHALL be 66 cycles.
REQ-023 The running max SHALL be reset per window; no value carries across windows or runs.
REQ-024 rd_addr, wr_addr, wr_data, we, status SHALL be registered outputs.

Reset
REQ-025 On reset, at the next edge:
- state=IDLE;
- rd_addr=0, wr_addr=0, wr_data=0, we=0, status=0;
- window counter and running max cleared.
REQ-026 Reset mid-RUN or mid-DRAIN SHALL drop any pending write: we=0 from the cycle after reset is sampled.
REQ-027 Reset SHALL take priority over control.

Verification
REQ-028 Ramp map, f[r][c]=8r+c-32; pulse control=1 -> 16 writes:
- addresses 0,4,...,60;
- data rows pr=0,1: all 0;
- pr=2: 9,11,13,15;
- pr=3: 25,27,29,31;
- status=1 at cycle 66 after RUN entry.
REQ-029 Address trace: first 8 rd_addr values in RUN are 0,4,32,36,8,12,40,44; the last is 252.
REQ-030 Signed/ReLU: one window = {0x80000000, 0xFFFFFFFF, 0x7FFFFFFF, 0} -> 0x7FFFFFFF; all four = 0xFFFFFFFE -> 0.
REQ-031 Handshake:
- control held 1 through DONE -> status stays 1, no second run;
- control=0 -> IDLE, status=0 next cycle;
- control=1 again -> identical second run.
REQ-032 Reset asserted at RUN k=30 for one cycle -> we=0 and state=IDLE from the next cycle; a new run from IDLE produces correct results.
REQ-033 control dropped to 0 at RUN k=10 -> run completes normally with all 16 writes.
